// File: rtl/qmf_subband_gain.sv
// ============================================================================
// Module   : qmf_subband_gain
// Brief    : Per-band Q1.15 gain with linear ramping, rounding and saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module qmf_subband_gain #(
    parameter int DATAW     = 16,
    parameter int GAINW     = 16,
    parameter int RAMP_LOG2 = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             gain_load,
    input  logic [GAINW-1:0] gain_low_target,
    input  logic [GAINW-1:0] gain_high_target,
    input  logic [DATAW-1:0] din_low,
    input  logic [DATAW-1:0] din_high,
    output logic [DATAW-1:0] dout_low,
    output logic [DATAW-1:0] dout_high,
    output logic             sat_low,
    output logic             sat_high,
    output logic [GAINW-1:0] gain_low_q,
    output logic [GAINW-1:0] gain_high_q,
    output logic             ramp_busy
);

    localparam int c_PW = DATAW + GAINW + 1;
    localparam logic [GAINW-1:0] c_UNITY = {1'b1, {(GAINW-1){1'b0}}};
    localparam logic [RAMP_LOG2-1:0] c_LAST = '1;
    localparam logic signed [c_PW-1:0] c_HALF = c_PW'(64'sd1 <<< (GAINW-2));
    localparam logic signed [c_PW-1:0] c_MAX  = c_PW'((64'sd1 <<< (DATAW-1)) - 64'sd1);
    localparam logic signed [c_PW-1:0] c_MIN  = -c_MAX - c_PW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic [RAMP_LOG2-1:0]    r_cnt;
    logic [GAINW-1:0]        r_tgt_low, r_tgt_high;
    logic [GAINW-1:0]        r_gain_low, r_gain_high;
    logic signed [GAINW:0]   r_step_low, r_step_high;
    logic [DATAW-1:0]        r_dout_low, r_dout_high;
    logic                    r_sat_low, r_sat_high;

    logic [DATAW:0]          w_scl_low, w_scl_high;

    // Floor-divided per-edge increment; the final snap absorbs the remainder.
    function automatic logic signed [GAINW:0] f_step(input logic [GAINW-1:0] tgt,
                                                      input logic [GAINW-1:0] cur);
        logic signed [GAINW:0] d;
        d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        return d >>> RAMP_LOG2;
    endfunction

    function automatic logic [GAINW-1:0] f_advance(input logic [GAINW-1:0]      cur,
                                                    input logic signed [GAINW:0] step);
        logic signed [GAINW:0] s;
        s = $signed({1'b0, cur}) + step;
        return s[GAINW-1:0];
    endfunction

    // Returns {sat, result}: round half up, then clip to the sample range.
    function automatic logic [DATAW:0] f_scale(input logic [DATAW-1:0] din,
                                               input logic [GAINW-1:0] gain);
        logic signed [c_PW-1:0] prod;
        logic signed [c_PW-1:0] shr;
        prod = $signed(din) * $signed({1'b0, gain});
        shr  = (prod + c_HALF) >>> (GAINW-1);
        if (shr > c_MAX)
            return {1'b1, c_MAX[DATAW-1:0]};
        else if (shr < c_MIN)
            return {1'b1, c_MIN[DATAW-1:0]};
        else
            return {1'b0, shr[DATAW-1:0]};
    endfunction

    always_comb begin
        w_scl_low  = f_scale(din_low,  r_gain_low);
        w_scl_high = f_scale(din_high, r_gain_high);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_tgt_low   <= c_UNITY;
            r_tgt_high  <= c_UNITY;
            r_gain_low  <= c_UNITY;
            r_gain_high <= c_UNITY;
            r_step_low  <= '0;
            r_step_high <= '0;
            r_dout_low  <= '0;
            r_dout_high <= '0;
            r_sat_low   <= 1'b0;
            r_sat_high  <= 1'b0;
        end else begin
            // Datapath uses the gain from before this edge's ramp update.
            if (en) begin
                r_dout_low  <= w_scl_low[DATAW-1:0];
                r_sat_low   <= w_scl_low[DATAW];
                r_dout_high <= w_scl_high[DATAW-1:0];
                r_sat_high  <= w_scl_high[DATAW];
            end

            // A load pre-empts any ramp update on the same edge, including the snap.
            if (gain_load) begin
                r_tgt_low   <= gain_low_target;
                r_tgt_high  <= gain_high_target;
                r_step_low  <= f_step(gain_low_target,  r_gain_low);
                r_step_high <= f_step(gain_high_target, r_gain_high);
                r_cnt       <= '0;
                r_state     <= S_RAMP;
                r_busy      <= 1'b1;
            end else if (en && (r_state == S_RAMP)) begin
                if (r_cnt == c_LAST) begin
                    r_gain_low  <= r_tgt_low;
                    r_gain_high <= r_tgt_high;
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                end else begin
                    r_gain_low  <= f_advance(r_gain_low,  r_step_low);
                    r_gain_high <= f_advance(r_gain_high, r_step_high);
                    r_cnt       <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign dout_low    = r_dout_low;
    assign dout_high   = r_dout_high;
    assign sat_low     = r_sat_low;
    assign sat_high    = r_sat_high;
    assign gain_low_q  = r_gain_low;
    assign gain_high_q = r_gain_high;
    assign ramp_busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_qmf_subband_gain.sv
// ============================================================================
// Module   : tb_qmf_subband_gain
// Brief    : Scoreboard plus vector-table bench for qmf_subband_gain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_qmf_subband_gain;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        gain_load;
    logic [15:0] gain_low_target, gain_high_target;
    logic [15:0] din_low, din_high;
    logic [15:0] dout_low, dout_high;
    logic        sat_low, sat_high;
    logic [15:0] gain_low_q, gain_high_q;
    logic        ramp_busy;

    always #5 clk = ~clk;

    qmf_subband_gain #(.DATAW(16), .GAINW(16), .RAMP_LOG2(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .gain_load        (gain_load),
        .gain_low_target  (gain_low_target),
        .gain_high_target (gain_high_target),
        .din_low          (din_low),
        .din_high         (din_high),
        .dout_low         (dout_low),
        .dout_high        (dout_high),
        .sat_low          (sat_low),
        .sat_high         (sat_high),
        .gain_low_q       (gain_low_q),
        .gain_high_q      (gain_high_q),
        .ramp_busy        (ramp_busy)
    );

    typedef struct {
        int dl; int dh; int sl; int sh;
    } exp_t;

    typedef struct {
        int din_l; int din_h;
        int exp_l; int exp_h;
        int sat_l; int sat_h;
    } vec_t;

    exp_t q_exp[$];
    exp_t last;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state of the gain ramp.
    int m_gl, m_gh, m_tl, m_th, m_sl, m_sh, m_cnt;
    int m_busy;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int ref_scale(input int d, input int g, output int s);
        longint r, q;
        r = longint'(d) * longint'(g) + 64'sd16384;
        q = (r >= 0) ? r / 32768 : -((-r + 32767) / 32768);
        s = 0;
        if (q > 32767) begin s = 1; q = 32767; end
        if (q < -32768) begin s = 1; q = -32768; end
        return int'(q);
    endfunction

    function automatic int ref_step(input int t, input int g);
        int d;
        d = t - g;
        return (d >= 0) ? d / 64 : -((-d + 63) / 64);
    endfunction

    task automatic model_reset();
        m_gl = 32768; m_gh = 32768; m_tl = 32768; m_th = 32768;
        m_sl = 0; m_sh = 0; m_cnt = 0; m_busy = 0;
        last = '{0, 0, 0, 0};
        q_exp.delete();
    endtask

    task automatic cycle(input int e, input int ld, input int t_l, input int t_h,
                         input int d_l, input int d_h);
        exp_t x, got;
        int   tl, th;
        tl = t_l; th = t_h;
        en = e[0]; gain_load = ld[0];
        gain_low_target = tl[15:0]; gain_high_target = th[15:0];
        din_low = d_l[15:0]; din_high = d_h[15:0];
        if (e != 0) begin
            x.dl = ref_scale(d_l, m_gl, x.sl);
            x.dh = ref_scale(d_h, m_gh, x.sh);
            q_exp.push_back(x);
        end
        if (ld != 0) begin
            m_tl = t_l; m_th = t_h;
            m_sl = ref_step(t_l, m_gl); m_sh = ref_step(t_h, m_gh);
            m_cnt = 0; m_busy = 1;
        end else if (e != 0 && m_busy != 0) begin
            if (m_cnt == 63) begin
                m_gl = m_tl; m_gh = m_th; m_busy = 0;
            end else begin
                m_gl = (m_gl + m_sl) & 16'hFFFF;
                m_gh = (m_gh + m_sh) & 16'hFFFF;
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        gain_load = 1'b0;
        if (e != 0) begin
            if (q_exp.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                last = q_exp.pop_front();
            end
        end
        got.dl = int'($signed(dout_low));  got.dh = int'($signed(dout_high));
        check("dout_low",  got.dl, last.dl);
        check("dout_high", got.dh, last.dh);
        check("sat_low",   int'(sat_low),  last.sl);
        check("sat_high",  int'(sat_high), last.sh);
        check("gain_low_q",  int'(gain_low_q),  m_gl);
        check("gain_high_q", int'(gain_high_q), m_gh);
        check("ramp_busy",   int'(ramp_busy),   m_busy);
    endtask

    task automatic run_en(input int n, input int d_l, input int d_h);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, d_l, d_h);
    endtask

    vec_t vecs[6];
    int   en_cnt;

    initial begin
        vecs[0] = '{ 30000,  10000,  32767,   5000, 1, 0};
        vecs[1] = '{-30000,     -3, -32768,     -1, 1, 0};
        vecs[2] = '{  1000,      1,   2000,      1, 0, 0};
        vecs[3] = '{    -1,     -1,     -2,      0, 0, 0};
        vecs[4] = '{ 16384, -32768,  32767, -16384, 1, 0};
        vecs[5] = '{ 16383,  32767,  32766,  16384, 0, 0};

        rst = 1'b1; en = 1'b0; gain_load = 1'b0;
        gain_low_target = '0; gain_high_target = '0; din_low = '0; din_high = '0;
        model_reset();
        #2;
        check("rst_dout_low",  int'(dout_low),    0);
        check("rst_dout_high", int'(dout_high),   0);
        check("rst_gain_low",  int'(gain_low_q),  32768);
        check("rst_gain_high", int'(gain_high_q), 32768);
        check("rst_busy",      int'(ramp_busy),   0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Unity pass-through.
        cycle(1, 0, 0, 0, 10000, -10000);
        check("unity_low",  int'($signed(dout_low)),  10000);
        check("unity_high", int'($signed(dout_high)), -10000);
        check("unity_sat",  int'(sat_low | sat_high), 0);

        // Ramp down, low band to zero.
        cycle(1, 1, 0, 32768, 10000, 0);
        run_en(32, 10000, 0);
        check("half_gain_low", int'(gain_low_q), 16384);
        run_en(1, 10000, 0);
        check("half_dout_low", int'($signed(dout_low)), 5000);
        run_en(31, 10000, 0);
        check("ramp_end_gain", int'(gain_low_q), 0);
        check("ramp_end_busy", int'(ramp_busy), 0);
        run_en(1, 10000, 0);
        check("zero_dout_low", int'($signed(dout_low)), 0);

        // Saturation table: low at 65535, high at 0.5.
        cycle(1, 1, 65535, 16384, 0, 0);
        run_en(64, 0, 0);
        check("sat_gain_low",  int'(gain_low_q),  65535);
        check("sat_gain_high", int'(gain_high_q), 16384);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 0, 0, vecs[i].din_l, vecs[i].din_h);
            check($sformatf("vec%0d_dl", i), int'($signed(dout_low)),  vecs[i].exp_l);
            check($sformatf("vec%0d_dh", i), int'($signed(dout_high)), vecs[i].exp_h);
            check($sformatf("vec%0d_sl", i), int'(sat_low),  vecs[i].sat_l);
            check($sformatf("vec%0d_sh", i), int'(sat_high), vecs[i].sat_h);
        end

        // Asynchronous reset in the middle of a ramp.
        cycle(1, 1, 0, 0, 20000, 20000);
        run_en(10, 20000, 20000);
        rst = 1'b1;
        #1;
        check("arst_gain_low",  int'(gain_low_q),  32768);
        check("arst_gain_high", int'(gain_high_q), 32768);
        check("arst_busy",      int'(ramp_busy),   0);
        check("arst_dout_low",  int'(dout_low),    0);
        check("arst_dout_high", int'(dout_high),   0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Truncation and final snap.
        cycle(1, 1, 32700, 32768, 100, 100);
        run_en(63, 100, 100);
        check("trunc_gain_63", int'(gain_low_q), 32642);
        check("trunc_busy_63", int'(ramp_busy), 1);
        run_en(1, 100, 100);
        check("snap_gain", int'(gain_low_q), 32700);
        check("snap_busy", int'(ramp_busy), 0);

        // Enable gating, then re-target mid-ramp.
        cycle(0, 1, 0, 65535, 0, 0);
        for (int i = 0; i < 40; i++) cycle((i % 2 == 0) ? 1 : 0, 0, 0, 0, 500, -500);
        check("gate_gain_low",  int'(gain_low_q),  22480);
        check("gate_gain_high", int'(gain_high_q), 42988);
        cycle(0, 1, 32768, 32768, 0, 0);
        en_cnt = 0;
        for (int i = 0; i < 200 && en_cnt < 64; i++) begin
            if (i % 2 == 1) en_cnt++;
            cycle(i % 2, 0, 0, 0, 700, -700);
            if (en_cnt < 64) check("retarget_busy", int'(ramp_busy), 1);
        end
        check("retarget_low",  int'(gain_low_q),  32768);
        check("retarget_high", int'(gain_high_q), 32768);
        check("retarget_done", int'(ramp_busy),   0);

        // Load landing on the final ramp step wins over the snap.
        cycle(1, 1, 16384, 16384, 0, 0);
        run_en(63, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check("coll_busy",     int'(ramp_busy),  1);
        check("coll_gain_low", int'(gain_low_q), 16640);
        run_en(64, 0, 0);
        check("coll_end_low",  int'(gain_low_q),  0);
        check("coll_end_high", int'(gain_high_q), 0);
        check("coll_end_busy", int'(ramp_busy),   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qmf_subband_gain.md
# qmf_subband_gain

Per-band gain stage placed directly upstream of `qmf_synthesis_core`, between the analysis outputs and the synthesis `din_low`/`din_high` inputs. It scales each subband sample by an unsigned Q1.15 gain. Gain changes ramp linearly over a fixed number of enabled samples, which avoids zipper noise in the reconstructed output. Products are rounded and saturated, and each result carries a per-sample saturation flag.

## Interface
- `DATAW`, 16: subband sample width, signed.
- `GAINW`, 16: gain width, unsigned Q1.15. 32768 = unity; 65535 ≈ 1.99997.
- `RAMP_LOG2`, 6: ramp length is 2^RAMP_LOG2 enabled cycles.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: sample strobe. Datapath and ramp advance only when `en`=1.
- `gain_load` in 1: single-cycle request to adopt new targets.
- `gain_low_target` in GAINW: target low-band gain, sampled on `gain_load`.
- `gain_high_target` in GAINW: target high-band gain, sampled on `gain_load`.
- `din_low` in DATAW: signed low-band sample.
- `din_high` in DATAW: signed high-band sample.
- `dout_low` out DATAW: scaled low band, registered.
- `dout_high` out DATAW: scaled high band, registered.
- `sat_low` out 1: high when the `dout_low` result was clipped.
- `sat_high` out 1: high when the `dout_high` result was clipped.
- `gain_low_q` out GAINW: current low-band gain.
- `gain_high_q` out GAINW: current high-band gain.
- `ramp_busy` out 1: high while in RAMP.

## Operation
- **Reset values:** `dout_*`=0, `sat_*`=0, `gain_*_q`=32768, targets=32768, step registers=0, ramp counter=0, state IDLE, `ramp_busy`=0.
- **States:** IDLE and RAMP.
- **Load:** `gain_load` is sampled every cycle, independent of `en`. In either state, on `gain_load`=1:
  - latch both targets;
  - compute `step_x = (target_x - gain_x_q) >>> RAMP_LOG2`, using a GAINW+1 signed difference and an arithmetic shift (floor);
  - clear the counter and enter RAMP.
- **RAMP, on each `en` cycle:**
  - If counter < 2^RAMP_LOG2 - 1: `gain_x_q += step_x`, counter++.
  - If counter == 2^RAMP_LOG2 - 1: `gain_x_q` = target exactly (snap, absorbs truncation), go IDLE.
- **Re-target mid-ramp:** `gain_load` during RAMP recomputes steps from the current gain and restarts the counter. Any previous target is discarded.
- **Load coinciding with the final ramp step:** the load wins. Targets and steps are recomputed from the pre-snap gain, and the block stays in RAMP.
- **Datapath, on each `en` cycle, per band:**
  - `prod = din * {1'b0, gain_q}`: DATAW+GAINW+1 signed.
  - Add 2^14, then arithmetic shift right by 15 (round half up).
  - Saturate to [-2^(DATAW-1), 2^(DATAW-1)-1]; `sat_x` = 1 if clipped.
  - Use `gain_q` as it was before that edge's ramp update.
- **`en`=0:** `dout_*`, `sat_*`, gains and counter hold.
- **`rst` mid-ramp:** returns to the reset values immediately (asynchronous), abandoning the ramp.

## Timing
- Data latency is 1 clock: `din` sampled at edge N with `en`=1 appears on `dout` after edge N.
- `ramp_busy` rises on the edge after `gain_load`. It falls on the edge that performs the snap, which is the 2^RAMP_LOG2-th `en` cycle after the load.
- A sample taken on the same edge as the k-th ramp update uses the gain after k-1 updates.
- Targets appear on `gain_*_q` exactly 2^RAMP_LOG2 `en` edges after the load, whether or not `en` gaps occur.

## Test plan
1. **Reset and unity:** assert `rst`, release it, then `en`=1 with `din_low`=10000 and `din_high`=-10000.
   - During reset: all `dout_*`=0 and `gain_*_q`=32768.
   - One cycle later: `dout_low`=10000, `dout_high`=-10000, `sat_*`=0.
2. **Ramp down:** `gain_load` with low target 0 and high target 32768, `en` held high, `din_low`=10000.
   - `step_low`=-512.
   - After 32 `en` cycles: `gain_low_q`=16384 and `dout_low`=5000 on the next sample.
   - After 64 `en` cycles: `gain_low_q`=0, `ramp_busy`=0, `dout_low` goes to 0.
3. **Saturation:** target 65535 fully ramped.
   - `din_low`=30000 → `dout_low`=32767, `sat_low`=1.
   - `din_low`=-30000 → `dout_low`=-32768, `sat_low`=1.
   - `din_low`=1000 → `dout_low`=2000, `sat_low`=0.
4. **Truncation snap:** from 32768, load target 32700, giving `step`=-2 (floor of -68/64).
   - After 63 steps: `gain_low_q`=32642.
   - 64th step: snaps to 32700.
5. **Enable gating and re-target:** start a ramp, toggle `en` every other cycle.
   - Gain changes only on `en` edges, and `ramp_busy` persists for 64 `en` cycles.
   - A mid-ramp `gain_load` to 32768 recomputes the step from the current gain and lands exactly at 32768 after 64 more `en` cycles.
6. **Reset mid-ramp:** assert `rst` after 10 ramp steps.
   - Gains return to 32768, `ramp_busy`=0, outputs go to 0 without waiting for a clock edge.
